// File: rtl/branch_pc_sequencer.sv
// -----------------------------------------------------------------------------
// branch_pc_sequencer
//
// Purpose:
//   This block owns the program counter and runs the multi-cycle conditional
//   branch stage. When a branch request is accepted, the stage does four things:
//     1. It latches the condition field ir[22:19] onto c2_out. The external
//        condition decoder and the CON flop use that value.
//     2. It waits SETTLE_CYCLES cycles so the CON flop can settle.
//     3. It samples con and loads PC with PC + sign_extend(ir[18:0]) when the
//        opcode is a conditional branch and con=1. Otherwise PC is unchanged.
//     4. It pulses br_done for one cycle, together with br_taken and
//        br_illegal.
//   While the stage is idle, it also handles the fetch increment (inc_pc) and
//   direct PC loads (pc_load). Those loads are used for jr/jal.
//
// Ports:
//   clk         in   system clock; all state updates on the rising edge
//   reset       in   synchronous active-high reset; overrides everything
//   inc_pc      in   fetch strobe, PC <= PC + 1 (IDLE only, lowest priority)
//   pc_load     in   direct load strobe, PC <= pc_in (IDLE only, top priority)
//   pc_in[31:0] in   direct load value
//   br_start    in   single-cycle branch request (IDLE only)
//   ir[31:0]    in   instruction register, stable from br_start to br_done
//   con         in   registered condition from the CON flip-flop
//   c2_out[3:0] out  ir[22:19] latched at the accepted br_start
//   pc_out[31:0]out  current PC
//   br_busy     out  high in every state except IDLE
//   br_done     out  one-cycle completion pulse
//   br_taken    out  valid with br_done: PC was loaded with the branch target
//   br_illegal  out  valid with br_done: opcode did not match BR_OPCODE
// -----------------------------------------------------------------------------
module branch_pc_sequencer #(
  parameter logic [4:0]  BR_OPCODE     = 5'b10010,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_pc,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  input  logic        br_start,
  input  logic [31:0] ir,
  input  logic        con,
  output logic [3:0]  c2_out,
  output logic [31:0] pc_out,
  output logic        br_busy,
  output logic        br_done,
  output logic        br_taken,
  output logic        br_illegal
);

  // The settle counter is 4 bits wide, which covers SETTLE_CYCLES values 1..15.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DECIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e      state_q,   state_d;
  logic [3:0]  cnt_q,     cnt_d;
  logic [31:0] pc_q,      pc_d;
  logic [3:0]  c2_q,      c2_d;
  logic [31:0] offset_q,  offset_d;
  logic        match_q,   match_d;
  logic        taken_q,   taken_d;
  logic        illegal_q, illegal_d;

  // ir[26:23] is not consumed by this stage.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[26:23];

  // Sign-extend the 19-bit branch displacement to 32 bits.
  // Copy bit 18 into all of the upper bits.
  logic [31:0] offset_ext;
  assign offset_ext[18:0] = ir[18:0];
  for (genvar gi = 19; gi < 32; gi++) begin : g_sext
    assign offset_ext[gi] = ir[18];
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pc_q      <= RESET_PC;
      c2_q      <= 4'd0;
      offset_q  <= 32'd0;
      match_q   <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      c2_q      <= c2_d;
      offset_q  <= offset_d;
      match_q   <= match_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    c2_d      = c2_q;
    offset_d  = offset_q;
    match_d   = match_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;

    unique case (state_q)
      ST_IDLE: begin
        // Only one request is served per cycle.
        // Any lower-priority request in the same cycle is dropped.
        if (pc_load) begin
          pc_d = pc_in;
        end else if (br_start) begin
          c2_d     = ir[22:19];
          offset_d = offset_ext;
          match_d  = (ir[31:27] == BR_OPCODE);
          cnt_d    = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end else if (inc_pc) begin
          pc_d = pc_q + 32'd1;
        end
      end

      ST_SETTLE: begin
        // The counter starts at SETTLE_CYCLES and leaves at 1.
        // So this state lasts exactly SETTLE_CYCLES cycles.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_DECIDE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DECIDE: begin
        // An illegal opcode never branches, whatever con says.
        if (match_q && con) begin
          pc_d    = pc_q + offset_q;
          taken_d = 1'b1;
        end else begin
          taken_d = 1'b0;
        end
        illegal_d = ~match_q;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        // Status flags are shown only during the DONE cycle.
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc_out     = pc_q;
  assign c2_out     = c2_q;
  assign br_busy    = (state_q != ST_IDLE);
  assign br_done    = (state_q == ST_DONE);
  assign br_taken   = taken_q;
  assign br_illegal = illegal_q;

endmodule
